// File: rtl/bin2bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// One BCD digit adjust for double-dabble: digits of 5 or more get +3 before the shift.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // 4-bit wrap is fine: a legal digit is at most 9, so 9+3=12 still fits.
  assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, with start/busy/done
// handshake and leading-zero blank flags for the display driver.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_SHIFT | shift-and-add-3 in progress, one input bit per edge
// ST_DONE  | result just published; start here chains the next conversion
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     bcd_out,
  output logic [DIGITS-1:0]       blank
);

  localparam int                BCD_W     = DIGIT_W * DIGITS;
  localparam int                CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  state_t           state;
  logic [WIDTH-1:0] shift_q;
  logic [BCD_W-1:0] scratch;
  logic [CNT_W-1:0] cnt;

  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  scratch_nxt;
  logic [WIDTH-1:0]  shift_nxt;
  logic [DIGITS-1:0] blank_nxt;
  logic              all_zero;

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[k*DIGIT_W +: DIGIT_W]),
      .dout (adj[k*DIGIT_W +: DIGIT_W])
    );
  end

  assign scratch_nxt = {adj[BCD_W-2:0], shift_q[WIDTH-1]};
  assign shift_nxt   = {shift_q[WIDTH-2:0], 1'b0};

  // Walk from the top digit down; a digit blanks only while everything above it is zero.
  always_comb begin
    blank_nxt = '0;
    all_zero  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero     = all_zero && (scratch_nxt[k*DIGIT_W +: DIGIT_W] == '0);
      blank_nxt[k] = all_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      blank   <= BLANK_RST;
      shift_q <= '0;
      scratch <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            shift_q <= bin_in;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          scratch <= scratch_nxt;
          shift_q <= shift_nxt;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            bcd_out <= scratch_nxt;
            blank   <= blank_nxt;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases, random values and a
// back-to-back sweep of every 8-bit input against a decimal arithmetic model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic [2:0]  blank;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .blank   (blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] model_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] model_blank(input int v);
    if (v < 10)  return 3'b110;
    if (v < 100) return 3'b100;
    return 3'b000;
  endfunction

  // Start a conversion; optionally fire a second (ignored) start after a few shifts.
  task automatic convert(input int val, input int pulse_at, input int pulse_val);
    int n;
    int dones;
    bin_in = 8'(val);
    start  = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    dones = 0;
    while (!done && n < 20) begin
      chk("busy_during", 32'(busy), 32'd1);
      bin_in = 8'($urandom);
      start  = (n == pulse_at);
      if (n == pulse_at) bin_in = 8'(pulse_val);
      step();
      start = 1'b0;
      n++;
    end
    chk("latency", 32'(n), 32'd8);
    chk("bcd", 32'(bcd_out), 32'(model_bcd(val)));
    chk("blank", 32'(blank), 32'(model_blank(val)));
    chk("busy_at_done", 32'(busy), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) dones++;
    end
    chk("single_done", 32'(dones), 32'd0);
    chk("bcd_hold", 32'(bcd_out), 32'(model_bcd(val)));
  endtask

  initial begin
    int t;
    int prev;
    int n;
    int dones;
    logic bad_digit;

    rst = 1'b1; start = 1'b0; bin_in = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_bcd", 32'(bcd_out), 32'h000);
    chk("rst_blank", 32'(blank), 32'b110);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 20; i++) begin
      bin_in = 8'($urandom);
      step();
      chk("idle_quiet", {busy, done, blank, bcd_out}, {2'b00, 3'b110, 12'h000});
    end

    convert(255, -1, 0);
    convert(7, -1, 0);
    convert(40, -1, 0);
    convert(200, -1, 0);
    convert(0, -1, 0);
    convert(128, 2, 99);
    for (int i = 0; i < 10; i++) convert(int'($urandom_range(0, 255)), -1, 0);

    // Reset in the middle of a conversion discards it.
    bin_in = 8'd255; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_bcd", 32'(bcd_out), 32'h000);
    chk("midrst_blank", 32'(blank), 32'b110);
    chk("midrst_busy", 32'(busy), 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) dones++;
    end
    chk("midrst_nodone", 32'(dones), 32'd0);
    convert(63, -1, 0);

    // Back-to-back sweep with start held high.
    t = 0;
    prev = -1;
    start = 1'b1;
    for (int v = 0; v < 256; v++) begin
      bin_in = 8'(v);
      n = 0;
      do begin
        step();
        t++;
        n++;
      end while (!done && n < 30);
      chk("exh_done", 32'(done), 32'd1);
      chk("exh_bcd", 32'(bcd_out), 32'(model_bcd(v)));
      chk("exh_blank", 32'(blank), 32'(model_blank(v)));
      bad_digit = (bcd_out[3:0] > 4'd9) || (bcd_out[7:4] > 4'd9) || (bcd_out[11:8] > 4'd9);
      chk("exh_digit", 32'(bad_digit), 32'd0);
      if (prev >= 0) chk("exh_gap", 32'(t - prev), 32'd9);
      prev = t;
    end
    start = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
